dds_cmd_scheduler: RTL and testbench
====================================

// Module: dds_cmd_scheduler
// PURPOSE
//   Queues 48-bit SPI command frames {cmd[47:40], payload[39:8], crc[7:0]} in the FPGA clock domain.
//   Checks each frame's CRC serially, executes it, and commits DDS pinc/ampl only on a phase-safe sync strobe.
//   Sits between the SPI slave receive path and the DDS core; returns a status byte for the next MISO reply.
// PARAMETERS
//   FIFO_DEPTH    4     command queue depth, power of 2, >=2
//   PINC_W        32    DDS phase-increment width
//   AMPL_W        12    DDS amplitude width
//   SYNC_TIMEOUT  1023  max cycles in WAIT_SYNC before a forced commit
// PORTS
//   i_Clk          in   1       FPGA clock; single clock domain
//   i_Rst          in   1       synchronous reset, active-high
//   i_Frame_DV     in   1       1-cycle pulse: i_Frame valid (already synchronised to i_Clk)
//   i_Frame        in   48      received command frame
//   i_Dds_Sync     in   1       DDS phase-accumulator wrap strobe; commit point
//   o_Pinc         out  PINC_W  active phase increment
//   o_Ampl         out  AMPL_W  active amplitude
//   o_Update       out  1       1-cycle pulse when o_Pinc or o_Ampl changes
//   o_Status       out  8       last status: 0x55 success, 0xAA fail
//   o_Status_DV    out  1       1-cycle pulse: o_Status written (load into SPI TX)
//   o_Overflow     out  1       1-cycle pulse: frame dropped, FIFO full
//   o_Err_Cnt      out  8       CRC-failure count, saturates at 0xFF
//   o_Busy         out  1       high when FSM not IDLE or FIFO not empty
// BEHAVIOUR
//   Reset values: o_Pinc=0, o_Ampl=0, o_Update=0, o_Status=0xAA, o_Status_DV=0, o_Overflow=0, o_Err_Cnt=0.
//   Reset also empties the FIFO and sends the FSM to IDLE. A reset mid-frame discards the frame with no status and no update.
//   FIFO write: i_Frame_DV pulse writes i_Frame.
//     If full and no pop in the same cycle: the frame is dropped and o_Overflow pulses.
//     If full and a pop occurs in the same cycle: the write is accepted.
//   FSM states: IDLE, POP, CRC, CHECK, WAIT_SYNC, COMMIT.
//     IDLE -> POP when the FIFO is not empty.
//     POP latches the head into r_Frame and pops. Then -> CHECK if cmd==0xCC, else -> CRC.
//     CRC runs 32 cycles, bit-serial, MSB first over payload[39:8]: poly 0x07, init 0x00, no reflect, no xorout.
//     CHECK:
//       cmd==0xCC: status pulse, o_Status unchanged (echo); -> IDLE.
//       CRC mismatch: o_Status=0xAA, o_Err_Cnt+1; -> IDLE.
//       CRC OK, cmd not in {0xAA, 0xBA}: o_Status=0xAA; -> IDLE.
//       CRC OK, cmd 0xAA or 0xBA: -> WAIT_SYNC.
//     WAIT_SYNC -> COMMIT on i_Dds_Sync==1 or when the wait counter reaches SYNC_TIMEOUT; counter clears on entry.
//     COMMIT:
//       cmd 0xAA: o_Pinc = payload[31:0].
//       cmd 0xBA: o_Ampl = payload[11:0]; payload bits above 11 ignored.
//       Both: o_Status=0x55, o_Update and o_Status_DV pulse; -> IDLE.
//   All outputs are registered.
//   Latency, idle block with empty FIFO, i_Frame_DV at cycle 0:
//     Frame visible in FIFO at c1; POP at c2.
//     0xCC: status pulse at c4.
//     CRC path: CRC c3..c34, CHECK c35; fail or invalid-cmd status pulse at c36.
//     Good 0xAA/0xBA: i_Dds_Sync sampled high in WAIT_SYNC at cycle k -> o_Update, o_Status_DV and new value at k+1.
//     i_Dds_Sync already high on the first WAIT_SYNC cycle (c36): commit visible at c37.
//   Frames are executed strictly in arrival order; only one frame is in flight.
//   i_Dds_Sync outside WAIT_SYNC is ignored.
//   Any status event clears no FIFO state. o_Err_Cnt does not wrap.
// STRUCTURE
//   Shared package dds_cmd_pkg:
//     CMD_PINC_SET=8'hAA, CMD_AMPL_SET=8'hBA, CMD_CHECK=8'hCC
//     STS_OK=8'h55, STS_FAIL=8'hAA, CRC_POLY=8'h07
//     FSM state encoding
//   Sub-module dds_cmd_fifo:
//     synchronous FIFO, FIFO_DEPTH x 48
//     ports: full, empty, wr, rd, same-cycle rd/wr when full allowed
//   The serial CRC register and the FSM stay in dds_cmd_scheduler.
// TESTING
//   1. Frame 0xAA_00000001_07, i_Dds_Sync pulsed at c50 -> o_Pinc=0x00000001 and o_Update at c51, o_Status=0x55; nothing changes before c51.
//   2. Frame 0xBA_00000001_07, i_Dds_Sync held high -> o_Ampl=0x001 at c37, o_Status=0x55, o_Pinc unchanged.
//   3. Frame 0xAA_00000001_00 (bad CRC) -> o_Status_DV at c36 with 0xAA, o_Err_Cnt=1, no o_Update.
//   4. Frame 0xCC_00000000_00 after test 1 -> o_Status_DV at c4, o_Status stays 0x55, no CRC cycles.
//   5. Six back-to-back frames with FIFO_DEPTH=4 and i_Dds_Sync low:
//        frame 1 is popped (c2), 2-5 fill the FIFO, 6 is dropped with o_Overflow;
//        then a SYNC_TIMEOUT forced commit for each frame, in order.
//   6. i_Rst asserted in CRC state of an 0xAA frame -> all outputs back to reset values next cycle; no o_Update/o_Status_DV afterwards.

Source files
------------

// File: rtl/dds_cmd_pkg.sv
// Shared constants and FSM encoding for the DDS command scheduler.
package dds_cmd_pkg;

    localparam int FRAME_W   = 48;
    localparam int PAYLOAD_W = 32;

    localparam logic [7:0] CMD_PINC_SET = 8'hAA;
    localparam logic [7:0] CMD_AMPL_SET = 8'hBA;
    localparam logic [7:0] CMD_CHECK    = 8'hCC;

    localparam logic [7:0] STS_OK   = 8'h55;
    localparam logic [7:0] STS_FAIL = 8'hAA;

    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_CRC,
        ST_CHECK,
        ST_WAIT_SYNC,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/dds_cmd_scheduler_if.sv
// Frame input, DDS sync and status/DDS outputs of the command scheduler.
interface dds_cmd_scheduler_if #(
    parameter int PINC_W = 32,
    parameter int AMPL_W = 12
) ();

    logic              i_Frame_DV;
    logic [47:0]       i_Frame;
    logic              i_Dds_Sync;
    logic [PINC_W-1:0] o_Pinc;
    logic [AMPL_W-1:0] o_Ampl;
    logic              o_Update;
    logic [7:0]        o_Status;
    logic              o_Status_DV;
    logic              o_Overflow;
    logic [7:0]        o_Err_Cnt;
    logic              o_Busy;

    // SPI receive path / DDS core side
    modport master (
        output i_Frame_DV, i_Frame, i_Dds_Sync,
        input  o_Pinc, o_Ampl, o_Update, o_Status, o_Status_DV,
               o_Overflow, o_Err_Cnt, o_Busy
    );

    // Scheduler side
    modport slave (
        input  i_Frame_DV, i_Frame, i_Dds_Sync,
        output o_Pinc, o_Ampl, o_Update, o_Status, o_Status_DV,
               o_Overflow, o_Err_Cnt, o_Busy
    );

endinterface

// File: rtl/dds_cmd_fifo.sv
// Synchronous command FIFO. The head entry is presented through a register,
// so it becomes valid two cycles after it is written; the scheduler never
// pops sooner than that. A write while full is accepted if a pop happens in
// the same cycle.
module dds_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Wr,
    input  logic [WIDTH-1:0] i_Wr_Data,
    input  logic             i_Rd,
    output logic [WIDTH-1:0] o_Rd_Data,
    output logic             o_Full,
    output logic             o_Empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             wr_en;
    logic             rd_en;

    assign o_Empty   = (wr_ptr_reg == rd_ptr_reg);
    assign o_Full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign wr_en     = i_Wr && (!o_Full || i_Rd);
    assign rd_en     = i_Rd && !o_Empty;
    assign o_Rd_Data = rd_data_reg;

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Storage write and registered head read
    always_ff @(posedge i_Clk) begin
        if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= i_Wr_Data;
        rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

endmodule

// File: rtl/dds_cmd_scheduler.sv
// Queues SPI command frames, checks their CRC-8 bit-serially, and commits
// DDS phase increment / amplitude only on the accumulator wrap strobe (or a
// timeout). Produces a status byte for the next MISO reply.
module dds_cmd_scheduler
    import dds_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int PINC_W       = 32,
    parameter int AMPL_W       = 12,
    parameter int SYNC_TIMEOUT = 1023
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    dds_cmd_scheduler_if.slave  bus
);

    localparam int                WAIT_W   = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SYNC_TIMEOUT);

    state_t               state_reg, state_next;
    logic [FRAME_W-1:0]   frame_reg;
    logic [PAYLOAD_W-1:0] shift_reg;
    logic [7:0]           crc_reg;
    logic [4:0]           bit_cnt_reg;
    logic [WAIT_W-1:0]    wait_cnt_reg;

    logic [PINC_W-1:0]    pinc_reg;
    logic [AMPL_W-1:0]    ampl_reg;
    logic                 update_reg;
    logic [7:0]           status_reg;
    logic                 status_dv_reg;
    logic                 overflow_reg;
    logic [7:0]           err_cnt_reg;
    logic                 busy_reg;

    logic                 fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FRAME_W-1:0]   fifo_head;

    logic                 sts_pulse;
    logic                 sts_fail;
    logic                 err_inc;
    logic                 commit;
    logic [7:0]           cmd;
    logic                 crc_fb;
    logic [7:0]           crc_step;

    assign cmd = frame_reg[47:40];

    dds_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Wr      (bus.i_Frame_DV),
        .i_Wr_Data (bus.i_Frame),
        .i_Rd      (fifo_rd),
        .o_Rd_Data (fifo_head),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty)
    );

    // One CRC-8 step per payload bit, MSB first: shift left, fold in the polynomial
    assign crc_fb      = crc_reg[7] ^ shift_reg[PAYLOAD_W-1];
    assign crc_step[0] = crc_fb & CRC_POLY[0];
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_crc_bit
            assign crc_step[gi] = crc_reg[gi-1] ^ (crc_fb & CRC_POLY[gi]);
        end
    endgenerate

    // Next-state and per-cycle control decode
    always_comb begin
        state_next = state_reg;
        fifo_rd    = 1'b0;
        sts_pulse  = 1'b0;
        sts_fail   = 1'b0;
        err_inc    = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) state_next = ST_POP;
            end
            ST_POP: begin
                fifo_rd    = 1'b1;
                state_next = (fifo_head[47:40] == CMD_CHECK) ? ST_CHECK : ST_CRC;
            end
            ST_CRC: begin
                if (bit_cnt_reg == 5'd31) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (cmd == CMD_CHECK) begin
                    sts_pulse = 1'b1;
                end else if (crc_reg != frame_reg[7:0]) begin
                    sts_pulse = 1'b1;
                    sts_fail  = 1'b1;
                    err_inc   = 1'b1;
                end else if (cmd == CMD_PINC_SET || cmd == CMD_AMPL_SET) begin
                    state_next = ST_WAIT_SYNC;
                end else begin
                    sts_pulse = 1'b1;
                    sts_fail  = 1'b1;
                end
            end
            ST_WAIT_SYNC: begin
                // Outputs load on this edge so the new value appears the cycle after the strobe
                if (bus.i_Dds_Sync || wait_cnt_reg == WAIT_MAX) begin
                    commit     = 1'b1;
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register, frame latch, serial CRC and sync wait counter
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg    <= ST_IDLE;
            frame_reg    <= '0;
            shift_reg    <= '0;
            crc_reg      <= '0;
            bit_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_POP) begin
                frame_reg   <= fifo_head;
                shift_reg   <= fifo_head[39:8];
                crc_reg     <= '0;
                bit_cnt_reg <= '0;
            end else if (state_reg == ST_CRC) begin
                crc_reg     <= crc_step;
                shift_reg   <= {shift_reg[PAYLOAD_W-2:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
            wait_cnt_reg <= (state_reg == ST_WAIT_SYNC) ? wait_cnt_reg + WAIT_W'(1) : '0;
        end
    end

    // Registered outputs: DDS values, status, pulses, error count and busy
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pinc_reg      <= '0;
            ampl_reg      <= '0;
            update_reg    <= 1'b0;
            status_reg    <= STS_FAIL;
            status_dv_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            err_cnt_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            update_reg    <= commit;
            status_dv_reg <= sts_pulse || commit;
            overflow_reg  <= bus.i_Frame_DV && fifo_full && !fifo_rd;
            busy_reg      <= (state_next != ST_IDLE) || !fifo_empty || bus.i_Frame_DV;
            if (sts_fail) status_reg <= STS_FAIL;
            if (commit) begin
                status_reg <= STS_OK;
                if (cmd == CMD_PINC_SET) pinc_reg <= frame_reg[8 +: PINC_W];
                if (cmd == CMD_AMPL_SET) ampl_reg <= frame_reg[8 +: AMPL_W];
            end
            if (err_inc && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign bus.o_Pinc      = pinc_reg;
    assign bus.o_Ampl      = ampl_reg;
    assign bus.o_Update    = update_reg;
    assign bus.o_Status    = status_reg;
    assign bus.o_Status_DV = status_dv_reg;
    assign bus.o_Overflow  = overflow_reg;
    assign bus.o_Err_Cnt   = err_cnt_reg;
    assign bus.o_Busy      = busy_reg;

endmodule

// File: tb/tb_dds_cmd_scheduler.sv
// Self-checking bench for dds_cmd_scheduler: a reference model predicts the
// DDS/status result of every accepted frame and queues it with the cycle it
// must appear on; each status pulse pops and compares one entry.
module tb_dds_cmd_scheduler;
    import dds_cmd_pkg::*;

    localparam int FIFO_DEPTH    = 4;
    localparam int PINC_W        = 32;
    localparam int AMPL_W        = 12;
    localparam int SYNC_TIMEOUT  = 1023;
    // Frame popped at c2, first WAIT_SYNC cycle c36, forced commit visible SYNC_TIMEOUT+1 later
    localparam int COMMIT_PERIOD = SYNC_TIMEOUT + 37;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;

    dds_cmd_scheduler_if #(.PINC_W(PINC_W), .AMPL_W(AMPL_W)) bus ();

    dds_cmd_scheduler #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PINC_W       (PINC_W),
        .AMPL_W       (AMPL_W),
        .SYNC_TIMEOUT (SYNC_TIMEOUT)
    ) dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic [31:0] pinc;
        logic [11:0] ampl;
        logic [7:0]  status;
        logic [7:0]  err;
        logic        upd;
    } res_t;

    typedef struct {
        res_t res;
        int   cyc;
    } exp_t;

    exp_t sb_q[$];
    res_t model;
    res_t rst_exp;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Byte-wise CRC-8, poly 0x07, init 0, over the 4 payload bytes MSB first
    function automatic logic [7:0] crc8_ref(input logic [31:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 3; b >= 0; b--) begin
            c = c ^ p[b*8 +: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [47:0] mk(input logic [7:0] c, input logic [31:0] p);
        return {c, p, crc8_ref(p)};
    endfunction

    function automatic res_t observe();
        res_t r;
        r.pinc   = bus.o_Pinc;
        r.ampl   = bus.o_Ampl;
        r.status = bus.o_Status;
        r.err    = bus.o_Err_Cnt;
        r.upd    = bus.o_Update;
        return r;
    endfunction

    task automatic step();
        @(posedge i_Clk);
        #1;
        cyc++;
        bus.i_Frame_DV = 1'b0;
    endtask

    // Drive one frame this cycle and queue the predicted result
    task automatic send(input logic [47:0] f, input int vis);
        exp_t       e;
        logic [7:0] c;
        logic [31:0] p;
        c = f[47:40];
        p = f[39:8];
        bus.i_Frame    = f;
        bus.i_Frame_DV = 1'b1;
        model.upd      = 1'b0;
        if (c != CMD_CHECK) begin
            if (crc8_ref(p) != f[7:0]) begin
                model.status = STS_FAIL;
                if (model.err != 8'hFF) model.err = model.err + 8'd1;
            end else if (c == CMD_PINC_SET) begin
                model.pinc = p;
                model.status = STS_OK;
                model.upd = 1'b1;
            end else if (c == CMD_AMPL_SET) begin
                model.ampl = p[11:0];
                model.status = STS_OK;
                model.upd = 1'b1;
            end else begin
                model.status = STS_FAIL;
            end
        end
        e.res = model;
        e.cyc = vis;
        sb_q.push_back(e);
        $display("c%0d send frame %h expect status %h at c%0d", cyc, f, model.status, vis);
    endtask

    task automatic test_reset();
        rst_exp        = '0;
        rst_exp.status = STS_FAIL;
        model          = rst_exp;
        i_Rst          = 1'b1;
        bus.i_Frame    = '0;
        bus.i_Frame_DV = 1'b0;
        bus.i_Dds_Sync = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (observe() !== rst_exp || {bus.o_Status_DV, bus.o_Overflow, bus.o_Busy} !== 3'b000)
            begin n_fail++; $display("FAIL reset_values: got %h/%b%b%b, want %h/000", observe(),
                bus.o_Status_DV, bus.o_Overflow, bus.o_Busy, rst_exp); end
        i_Rst = 1'b0;
        step();
    endtask

    task automatic test_pinc_sync_pulse();
        res_t prev;
        exp_t e;
        bit   seen = 0;
        sb_q.delete();
        prev = model;
        prev.upd = 1'b0;
        step(); cyc = 0;
        send(48'hAA_00000001_07, 51);
        while (cyc < 60) begin
            step();
            if (cyc == 1) begin
                n_cmp++;
                if (bus.o_Busy !== 1'b1) begin n_fail++; $display("FAIL pinc_busy: got %b, want 1", bus.o_Busy); end
            end
            if (cyc < 51) begin
                n_cmp++;
                if (observe() !== prev || bus.o_Status_DV !== 1'b0)
                    begin n_fail++; $display("FAIL pinc_early_change c%0d: got %h, want %h", cyc, observe(), prev); end
            end
            if (bus.o_Status_DV) begin
                seen = 1;
                if (sb_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL pinc_extra_status at c%0d", cyc); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp += 2;
                    if (observe() !== e.res) begin n_fail++; $display("FAIL pinc_result: got %h, want %h", observe(), e.res); end
                    if (cyc != e.cyc) begin n_fail++; $display("FAIL pinc_latency: got c%0d, want c%0d", cyc, e.cyc); end
                    $display("c%0d commit pinc=%h status=%h", cyc, bus.o_Pinc, bus.o_Status);
                end
            end
            bus.i_Dds_Sync = (cyc == 50);
        end
        n_cmp += 2;
        if (!seen) begin n_fail++; $display("FAIL pinc_timeout: got no status pulse, want one at c51"); end
        if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL pinc_idle_busy: got %b, want 0", bus.o_Busy); end
    endtask

    task automatic test_echo();
        exp_t e;
        bit   seen = 0;
        sb_q.delete();
        step(); cyc = 0;
        send(48'hCC_00000000_00, 4);
        while (cyc < 10) begin
            step();
            if (bus.o_Status_DV) begin
                seen = 1;
                if (sb_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL echo_extra_status at c%0d", cyc); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp += 2;
                    if (observe() !== e.res) begin n_fail++; $display("FAIL echo_result: got %h, want %h", observe(), e.res); end
                    if (cyc != e.cyc) begin n_fail++; $display("FAIL echo_latency: got c%0d, want c%0d", cyc, e.cyc); end
                    $display("c%0d echo status=%h", cyc, bus.o_Status);
                end
            end
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL echo_timeout: got no status pulse, want one at c4"); end
    endtask

    task automatic test_ampl_sync_held();
        exp_t e;
        bit   seen = 0;
        sb_q.delete();
        step(); cyc = 0;
        bus.i_Dds_Sync = 1'b1;
        send(48'hBA_00000001_07, 37);
        while (cyc < 45) begin
            step();
            if (bus.o_Status_DV) begin
                seen = 1;
                if (sb_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL ampl_extra_status at c%0d", cyc); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp += 2;
                    if (observe() !== e.res) begin n_fail++; $display("FAIL ampl_result: got %h, want %h", observe(), e.res); end
                    if (cyc != e.cyc) begin n_fail++; $display("FAIL ampl_latency: got c%0d, want c%0d", cyc, e.cyc); end
                    $display("c%0d commit ampl=%h pinc=%h", cyc, bus.o_Ampl, bus.o_Pinc);
                end
            end else begin
                n_cmp++;
                if (bus.o_Update !== 1'b0) begin n_fail++; $display("FAIL ampl_stray_update c%0d: got 1, want 0", cyc); end
            end
        end
        bus.i_Dds_Sync = 1'b0;
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL ampl_timeout: got no status pulse, want one at c37"); end
    endtask

    task automatic test_reject();
        logic [47:0] frames [2];
        exp_t e;
        bit   seen;
        frames[0] = 48'hAA_00000001_00;          // CRC mismatch
        frames[1] = mk(8'h12, 32'h00C0FFEE);     // good CRC, unknown command
        for (int i = 0; i < 2; i++) begin
            sb_q.delete();
            seen = 0;
            step(); cyc = 0;
            bus.i_Dds_Sync = 1'b1;
            send(frames[i], 36);
            while (cyc < 45) begin
                step();
                if (bus.o_Status_DV) begin
                    seen = 1;
                    if (sb_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL reject_extra_status at c%0d", cyc); end
                    else begin
                        e = sb_q.pop_front();
                        n_cmp += 2;
                        if (observe() !== e.res) begin n_fail++; $display("FAIL reject_result %0d: got %h, want %h", i, observe(), e.res); end
                        if (cyc != e.cyc) begin n_fail++; $display("FAIL reject_latency %0d: got c%0d, want c%0d", i, cyc, e.cyc); end
                        $display("c%0d reject status=%h err=%0d", cyc, bus.o_Status, bus.o_Err_Cnt);
                    end
                end else begin
                    n_cmp++;
                    if (bus.o_Update !== 1'b0) begin n_fail++; $display("FAIL reject_stray_update c%0d: got 1, want 0", cyc); end
                end
            end
            bus.i_Dds_Sync = 1'b0;
            n_cmp++;
            if (!seen) begin n_fail++; $display("FAIL reject_timeout %0d: got no status pulse, want one at c36", i); end
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] frames [6];
        exp_t e;
        frames[0] = mk(CMD_PINC_SET, 32'h00000010);
        frames[1] = mk(CMD_AMPL_SET, 32'hABCDE5A5);
        frames[2] = mk(CMD_PINC_SET, 32'hDEADBEEF);
        frames[3] = mk(CMD_AMPL_SET, 32'h00000123);
        frames[4] = mk(CMD_PINC_SET, 32'h0000ABCD);
        frames[5] = mk(CMD_PINC_SET, 32'h11111111);
        sb_q.delete();
        bus.i_Dds_Sync = 1'b0;
        step(); cyc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) send(frames[i], COMMIT_PERIOD * (i + 1));
            else begin
                // sixth frame meets a full FIFO and must be dropped: no expectation
                bus.i_Frame    = frames[i];
                bus.i_Frame_DV = 1'b1;
                $display("c%0d send frame %h expect overflow at c6", cyc, frames[i]);
            end
            step();
            n_cmp++;
            if (bus.o_Overflow !== (cyc == 6))
                begin n_fail++; $display("FAIL b2b_overflow c%0d: got %b, want %b", cyc, bus.o_Overflow, (cyc == 6)); end
        end
        while (cyc < 6 * COMMIT_PERIOD + 50) begin
            step();
            n_cmp++;
            if (bus.o_Overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_late_overflow c%0d: got 1, want 0", cyc); end
            if (bus.o_Status_DV) begin
                if (sb_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL b2b_extra_status at c%0d status=%h", cyc, bus.o_Status); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp += 2;
                    if (observe() !== e.res) begin n_fail++; $display("FAIL b2b_result: got %h, want %h", observe(), e.res); end
                    if (cyc != e.cyc) begin n_fail++; $display("FAIL b2b_latency: got c%0d, want c%0d", cyc, e.cyc); end
                    $display("c%0d timeout commit pinc=%h ampl=%h", cyc, bus.o_Pinc, bus.o_Ampl);
                end
            end else begin
                n_cmp++;
                if (bus.o_Update !== 1'b0) begin n_fail++; $display("FAIL b2b_stray_update c%0d: got 1, want 0", cyc); end
            end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: got %0d uncommitted, want 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        sb_q.delete();
        step(); cyc = 0;
        // this frame is aborted by reset, so no result is expected for it
        bus.i_Frame    = mk(CMD_PINC_SET, 32'h12345678);
        bus.i_Frame_DV = 1'b1;
        $display("c%0d send frame %h, reset at c10", cyc, bus.i_Frame);
        while (cyc < 10) step();
        i_Rst = 1'b1;
        step();
        i_Rst = 1'b0;
        model = rst_exp;
        n_cmp++;
        if (observe() !== rst_exp || {bus.o_Status_DV, bus.o_Overflow, bus.o_Busy} !== 3'b000)
            begin n_fail++; $display("FAIL midreset_values: got %h/%b%b%b, want %h/000", observe(),
                bus.o_Status_DV, bus.o_Overflow, bus.o_Busy, rst_exp); end
        while (cyc < 1200) begin
            bus.i_Dds_Sync = cyc[0];
            step();
            n_cmp++;
            if (bus.o_Status_DV !== 1'b0 || bus.o_Update !== 1'b0)
                begin n_fail++; $display("FAIL midreset_activity c%0d: got dv=%b upd=%b, want 0 0", cyc, bus.o_Status_DV, bus.o_Update); end
        end
        bus.i_Dds_Sync = 1'b0;
        n_cmp++;
        if (observe() !== rst_exp || bus.o_Busy !== 1'b0)
            begin n_fail++; $display("FAIL midreset_final: got %h busy=%b, want %h busy=0", observe(), bus.o_Busy, rst_exp); end
        $display("c%0d reset mid-frame done", cyc);
    endtask

    initial begin
        test_reset();
        test_pinc_sync_pulse();
        test_echo();
        test_ampl_sync_held();
        test_reject();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
